// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c master among NUM_REQ sensor requesters.
// Latches the winner's descriptor, launches the master, returns data/done/err, guards with a timeout.
module i2c_bus_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*7-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [NUM_REQ-1:0]     req_two_bytes,
  input  logic [NUM_REQ*16-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [15:0]            rdata,
  output logic                   busy,
  output logic                   m_start,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic                   m_two_bytes,
  output logic [15:0]            m_data,
  input  logic [15:0]            m_read_data,
  input  logic                   m_ready
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);
  // Timer value whose increment would reach TIMEOUT-1: the last cycle before abort.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, COMPLETE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]        ptr_reg, ptr_next;
  logic [IW-1:0]        sel_reg, sel_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic                 err_reg, err_next;
  logic [15:0]          rdata_reg, rdata_next;
  logic [6:0]           addr_reg, addr_next;
  logic                 rw_reg, rw_next;
  logic                 two_reg, two_next;
  logic [15:0]          data_reg, data_next;

  logic [6:0]           addr_arr  [NUM_REQ];
  logic [15:0]          wdata_arr [NUM_REQ];
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;
  logic                 expired;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign wdata_arr[gi] = req_wdata[16*gi +: 16];
    end
  endgenerate

  // First requesting index after the pointer, wrapping; the last-served index ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_reg) + k) % NUM_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign expired = (timer_reg >= T_LAST);

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    rdata_next = rdata_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    two_next   = two_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (m_ready && pick_found) begin
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
          sel_next           = pick_idx;
          addr_next          = addr_arr[pick_idx];
          rw_next            = req_rw[pick_idx];
          two_next           = req_two_bytes[pick_idx];
          data_next          = wdata_arr[pick_idx];
          state_next         = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        err_next   = 1'b0;
        state_next = WAIT_ACCEPT;
      end
      WAIT_ACCEPT, WAIT_DONE: begin
        timer_next = expired ? timer_reg : timer_reg + TW'(1);
        if (state_reg == WAIT_ACCEPT && !m_ready) begin
          state_next = WAIT_DONE;
        end else if (state_reg == WAIT_DONE && m_ready) begin
          rdata_next = m_read_data;
          err_next   = 1'b0;
          state_next = COMPLETE;
        end else if (expired) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = COMPLETE;
        end
      end
      COMPLETE: begin
        ptr_next   = sel_reg;
        gnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ptr_reg   <= PTR_INIT;
      sel_reg   <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
      addr_reg  <= '0;
      rw_reg    <= 1'b0;
      two_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      addr_reg  <= addr_next;
      rw_reg    <= rw_next;
      two_reg   <= two_next;
      data_reg  <= data_next;
    end
  end

  assign gnt         = gnt_reg;
  assign done        = (state_reg == COMPLETE) ? gnt_reg : '0;
  assign err         = (state_reg == COMPLETE) && err_reg;
  assign rdata       = rdata_reg;
  assign busy        = (state_reg != IDLE);
  assign m_start     = (state_reg == ISSUE);
  assign m_addr      = addr_reg;
  assign m_rw        = rw_reg;
  assign m_two_bytes = two_reg;
  assign m_data      = data_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a behavioural master whose accept delay and busy time are adjustable.
module tb_i2c_bus_arbiter;
  localparam int N  = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*7-1:0]  req_addr;
  logic [N-1:0]    req_rw;
  logic [N-1:0]    req_two_bytes;
  logic [N*16-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic            err, busy, m_start, m_rw, m_two_bytes, m_ready;
  logic [15:0]     rdata, m_data;
  logic [6:0]      m_addr;
  logic [15:0]     m_read_data = '0;

  logic        mdl_ready = 1'b1;
  logic        force_nr = 1'b0;
  logic        master_en = 1'b1;
  logic [15:0] resp_data = '0;
  int          accept_dly = 1;
  int          busy_cycles = 3;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [6:0]  exp_addr [N];

  assign m_ready = force_nr ? 1'b0 : mdl_ready;

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_two_bytes(req_two_bytes), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .busy(busy), .m_start(m_start), .m_addr(m_addr),
    .m_rw(m_rw), .m_two_bytes(m_two_bytes), .m_data(m_data),
    .m_read_data(m_read_data), .m_ready(m_ready)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master: drops ready accept_dly cycles after the start cycle, stays busy busy_cycles, then returns data.
  initial forever begin
    @(negedge clk);
    if (m_start === 1'b1 && master_en) begin
      repeat (accept_dly) @(posedge clk);
      #1 mdl_ready = 1'b0;
      repeat (busy_cycles) @(posedge clk);
      #1 mdl_ready = 1'b1;
      m_read_data = resp_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_start === 1'b1) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic wait_done(output bit ok, output int t, output int nstart);
    ok = 1'b0; t = 0; nstart = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_start === 1'b1) nstart++;
      if (done !== '0) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    rst = 1'b1; tick(); tick();
    n_checks++; if (gnt !== 8'h00) $display("FAIL reset_gnt: got %h expected 00", gnt); else n_pass++;
    n_checks++; if (done !== 8'h00 || err !== 1'b0) $display("FAIL reset_done_err: got %h/%b expected 00/0", done, err); else n_pass++;
    n_checks++; if (busy !== 1'b0 || m_start !== 1'b0) $display("FAIL reset_busy_start: got %b/%b expected 0/0", busy, m_start); else n_pass++;
    n_checks++; if (rdata !== 16'h0) $display("FAIL reset_rdata: got %h expected 0000", rdata); else n_pass++;
    n_checks++; if (m_addr !== 7'h0 || m_data !== 16'h0) $display("FAIL reset_m_addr_data: got %h/%h expected 00/0000", m_addr, m_data); else n_pass++;
    n_checks++; if (m_rw !== 1'b0 || m_two_bytes !== 1'b0) $display("FAIL reset_m_rw_two: got %b/%b expected 0/0", m_rw, m_two_bytes); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bit ok; int t0, t1, ns;
    accept_dly = 2; busy_cycles = 40; resp_data = 16'hA5C3;
    req = 8'h08;
    tick();
    t0 = cyc;
    n_checks++; if (gnt !== 8'h08 || m_start !== 1'b1) $display("FAIL single_gnt_start: got %h/%b expected 08/1", gnt, m_start); else n_pass++;
    n_checks++; if (m_addr !== 7'h4B || m_rw !== 1'b1 || m_two_bytes !== 1'b1) $display("FAIL single_desc: got %h/%b/%b expected 4b/1/1", m_addr, m_rw, m_two_bytes); else n_pass++;
    n_checks++; if (m_data !== 16'hC003) $display("FAIL single_m_data: got %h expected c003", m_data); else n_pass++;
    req_addr[21 +: 7] = 7'h00;
    wait_done(ok, t1, ns);
    n_checks++; if (!ok) $display("FAIL single_done_wait: got timeout expected done"); else n_pass++;
    n_checks++; if (done !== 8'h08 || err !== 1'b0) $display("FAIL single_done_err: got %h/%b expected 08/0", done, err); else n_pass++;
    n_checks++; if (rdata !== 16'hA5C3) $display("FAIL single_rdata: got %h expected a5c3", rdata); else n_pass++;
    n_checks++; if (t1 - t0 !== 2 + 40 + 1) $display("FAIL single_latency: got %0d expected 43", t1 - t0); else n_pass++;
    n_checks++; if (ns !== 0) $display("FAIL single_extra_start: got %0d expected 0", ns); else n_pass++;
    n_checks++; if (m_addr !== 7'h4B) $display("FAIL single_addr_hold: got %h expected 4b", m_addr); else n_pass++;
    req_addr[21 +: 7] = 7'h4B;
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok; int t0, t1, ns; logic [7:0] e1; int idx;
    accept_dly = 1; busy_cycles = 3;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      idx = k % N;
      e1 = 8'b1 << idx;
      resp_data = 16'h0100 + 16'(k);
      wait_start(ok, t0);
      n_checks++; if (!ok || gnt !== e1) $display("FAIL rr_gnt%0d: got %h expected %h", k, gnt, e1); else n_pass++;
      n_checks++; if (m_addr !== exp_addr[idx]) $display("FAIL rr_addr%0d: got %h expected %h", k, m_addr, exp_addr[idx]); else n_pass++;
      wait_done(ok, t1, ns);
      n_checks++; if (!ok || done !== e1 || ns !== 0 || t1 - t0 !== 5) $display("FAIL rr_done%0d: got %h starts %0d lat %0d expected %h 0 5", k, done, ns, t1 - t0, e1); else n_pass++;
      if (k == 8) req = '0;
    end
    tick();
  endtask

  task automatic test_priority_rotation();
    bit ok; int t0, t1, ns;
    resp_data = 16'h5A5A;
    req = 8'h20;
    wait_start(ok, t0);
    wait_done(ok, t1, ns);
    n_checks++; if (!ok || done !== 8'h20) $display("FAIL rot_first: got %h expected 20", done); else n_pass++;
    req = 8'h21;
    wait_start(ok, t0);
    n_checks++; if (!ok || gnt !== 8'h01) $display("FAIL rot_wrap: got %h expected 01", gnt); else n_pass++;
    wait_done(ok, t1, ns);
    req = 8'h20;
    wait_start(ok, t0);
    n_checks++; if (!ok || gnt !== 8'h20) $display("FAIL rot_second: got %h expected 20", gnt); else n_pass++;
    wait_done(ok, t1, ns);
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    bit ok; int t0, t1, ns;
    master_en = 1'b0;
    req = 8'h04;
    wait_start(ok, t0);
    wait_done(ok, t1, ns);
    n_checks++; if (!ok || done !== 8'h04) $display("FAIL to_done: got %h expected 04", done); else n_pass++;
    n_checks++; if (t1 - t0 !== TO) $display("FAIL to_latency: got %0d expected %0d", t1 - t0, TO); else n_pass++;
    n_checks++; if (err !== 1'b1 || rdata !== 16'h0) $display("FAIL to_err_rdata: got %b/%h expected 1/0000", err, rdata); else n_pass++;
    master_en = 1'b1; resp_data = 16'h1234;
    req = 8'h02;
    wait_start(ok, t0);
    n_checks++; if (!ok || gnt !== 8'h02) $display("FAIL to_next_gnt: got %h expected 02", gnt); else n_pass++;
    wait_done(ok, t1, ns);
    n_checks++; if (!ok || err !== 1'b0 || rdata !== 16'h1234) $display("FAIL to_next_done: got %b/%h expected 0/1234", err, rdata); else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_not_ready();
    bit ok; int t1, ns; int bad;
    bad = 0;
    force_nr = 1'b1;
    req = 8'h01;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt !== 8'h00 || m_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL nr_hold: got %0d bad cycles expected 0", bad); else n_pass++;
    force_nr = 1'b0;
    tick();
    n_checks++; if (gnt !== 8'h01 || m_start !== 1'b1) $display("FAIL nr_grant: got %h/%b expected 01/1", gnt, m_start); else n_pass++;
    wait_done(ok, t1, ns);
    n_checks++; if (!ok || done !== 8'h01) $display("FAIL nr_done: got %h expected 01", done); else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; int t0, t1, ns; int bad;
    busy_cycles = 20; resp_data = 16'h7777;
    req = 8'h01;
    wait_start(ok, t0);
    repeat (4) tick();
    n_checks++; if (busy !== 1'b1 || gnt !== 8'h01) $display("FAIL rm_pre: got %b/%h expected 1/01", busy, gnt); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    n_checks++; if (gnt !== 8'h00 || done !== 8'h00 || busy !== 1'b0 || m_start !== 1'b0) $display("FAIL rm_ctrl: got %h/%h/%b/%b expected 00/00/0/0", gnt, done, busy, m_start); else n_pass++;
    n_checks++; if (rdata !== 16'h0 || m_addr !== 7'h0 || m_data !== 16'h0) $display("FAIL rm_data: got %h/%h/%h expected 0", rdata, m_addr, m_data); else n_pass++;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done !== 8'h00 || err !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL rm_no_done: got %0d done cycles expected 0", bad); else n_pass++;
    req = 8'h09;
    wait_start(ok, t0);
    n_checks++; if (!ok || gnt !== 8'h01) $display("FAIL rm_first: got %h expected 01", gnt); else n_pass++;
    wait_done(ok, t1, ns);
    n_checks++; if (!ok || done !== 8'h01 || rdata !== 16'h7777) $display("FAIL rm_done: got %h/%h expected 01/7777", done, rdata); else n_pass++;
    req = '0;
    tick();
  endtask

  initial begin
    req_rw = 8'hAA;
    req_two_bytes = 8'h0F;
    for (int i = 0; i < N; i++) begin
      exp_addr[i] = (i == 3) ? 7'h4B : 7'(7'h10 + i);
      req_addr[7*i +: 7] = exp_addr[i];
      req_wdata[16*i +: 16] = 16'(16'hC000 + i);
    end
    test_reset();
    test_single_read();
    apply_reset();
    test_round_robin();
    test_priority_rotation();
    test_timeout();
    test_not_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
